// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that lets two requesters share one
// combinational ALU. Each accepted operation takes three cycles
// (IDLE -> EXEC -> DONE). The operands are latched at grant and the ALU
// result and flags are captured at the end of EXEC.
module alu_arbiter #(
  parameter logic [4:0] IDLE_FS = 5'h13,
  parameter int         DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [4:0]        fs0,
  input  logic [4:0]        fs1,
  input  logic [DATA_W-1:0] s0,
  input  logic [DATA_W-1:0] t0,
  input  logic [DATA_W-1:0] s1,
  input  logic [DATA_W-1:0] t1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] y_lo,
  output logic              n,
  output logic              z,
  output logic              v,
  output logic              c,
  output logic [4:0]        alu_fs,
  output logic [DATA_W-1:0] alu_s,
  output logic [DATA_W-1:0] alu_t,
  input  logic [DATA_W-1:0] alu_y_lo,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              alu_c
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            state_q, state_d;
  logic              last_q;   // port served most recently; also the port in flight
  logic              win;
  logic              any_req;
  logic [4:0]        fs_p0;
  logic [DATA_W-1:0] s_p0, t_p0;

  // Arbitration: a lone request wins; on a tie the port not served last wins
  always_comb begin
    any_req = req0 | req1;
    win     = 1'b0;
    if (req0 && req1) win = ~last_q;
    else if (req1)    win = 1'b1;
  end

  // Next-state logic and decode of the grant, done and ALU-drive outputs
  always_comb begin
    state_d = state_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    done0   = 1'b0;
    done1   = 1'b0;
    alu_fs  = IDLE_FS;
    alu_s   = '0;
    alu_t   = '0;
    case (state_q)
      IDLE: if (any_req) state_d = EXEC;
      EXEC: begin
        state_d = DONE;
        gnt0    = ~last_q;
        gnt1    = last_q;
        alu_fs  = fs_p0;
        alu_s   = s_p0;
        alu_t   = t_p0;
      end
      DONE: begin
        state_d = IDLE;
        done0   = ~last_q;
        done1   = last_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and last-served pointer; the pointer moves only on a grant
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) last_q <= win;
    end
  end

  // Stage p0: latch the winning port's function select and operands at grant
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_p0 <= '0;
      s_p0  <= '0;
      t_p0  <= '0;
    end else if (state_q == IDLE && any_req) begin
      fs_p0 <= win ? fs1 : fs0;
      s_p0  <= win ? s1  : s0;
      t_p0  <= win ? t1  : t0;
    end
  end

  // Result stage: capture the ALU output at the end of EXEC and hold it until the next capture
  always_ff @(posedge clk) begin
    if (reset) begin
      y_lo <= '0;
      n    <= 1'b0;
      z    <= 1'b0;
      v    <= 1'b0;
      c    <= 1'b0;
    end else if (state_q == EXEC) begin
      y_lo <= alu_y_lo;
      n    <= alu_n;
      z    <= alu_z;
      v    <= alu_v;
      c    <= alu_c;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. It supplies a small ALU model and directed
// stimulus, and checks the results through a scoreboard queue.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [4:0]  fs0, fs1;
  logic [31:0] s0, t0, s1, t1;
  logic        gnt0, gnt1, done0, done1;
  logic [31:0] y_lo;
  logic        n, z, v, c;
  logic [4:0]  alu_fs;
  logic [31:0] alu_s, alu_t;
  logic [31:0] alu_y_lo;
  logic        alu_n, alu_z, alu_v, alu_c;

  typedef struct packed {
    logic        port;
    logic [31:0] y;
    logic [3:0]  f;   // {n,z,v,c}
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.IDLE_FS(5'h13), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .fs0(fs0), .fs1(fs1),
    .s0(s0), .t0(t0), .s1(s1), .t1(t1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .y_lo(y_lo), .n(n), .z(z), .v(v), .c(c),
    .alu_fs(alu_fs), .alu_s(alu_s), .alu_t(alu_t),
    .alu_y_lo(alu_y_lo), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c)
  );

  // Shared ALU: 02 add, 03 sub (c = borrow), 09 or, anything else xor
  logic [32:0] sum;
  always_comb begin
    sum      = {1'b0, alu_s} + {1'b0, alu_t};
    alu_y_lo = alu_s ^ alu_t;
    alu_v    = 1'b0;
    alu_c    = 1'b0;
    case (alu_fs)
      5'h02: begin
        alu_y_lo = sum[31:0];
        alu_c    = sum[32];
        alu_v    = (alu_s[31] == alu_t[31]) && (sum[31] != alu_s[31]);
      end
      5'h03: begin
        alu_y_lo = alu_s - alu_t;
        alu_c    = alu_s < alu_t;
        alu_v    = (alu_s[31] != alu_t[31]) && (alu_y_lo[31] != alu_s[31]);
      end
      5'h09: alu_y_lo = alu_s | alu_t;
      default: ;
    endcase
    alu_n = alu_y_lo[31];
    alu_z = (alu_y_lo == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever a done pulse appears; check exclusivity every cycle
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("exclusive", 32'((gnt0 & gnt1) | (done0 & done1) | ((gnt0 | gnt1) & (done0 | done1))), 32'd0);
      if (done0 | done1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=done0:%b,done1:%b required=none", done0, done1);
        end else begin
          e = sb.pop_front();
          chk("done_port", 32'(done1), 32'(e.port));
          chk("done_single", 32'(done0 ^ done1), 32'd1);
          chk("y_lo", y_lo, e.y);
          chk("flags_nzvc", 32'({n, z, v, c}), 32'(e.f));
        end
      end
    end
  end

  task automatic drive(input bit p, input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t);
    if (p) begin fs1 = fs; s1 = s; t1 = t; req1 = 1'b1; end
    else   begin fs0 = fs; s0 = s; t0 = t; req0 = 1'b1; end
  endtask

  task automatic wait_done(input bit p, output int at);
    at = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if ((p ? done1 : done0) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL done_timeout port=%0d actual=none required=pulse", p);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ta, tb, tg, cnt;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    fs0 = '0; fs1 = '0; s0 = '0; t0 = '0; s1 = '0; t1 = '0;
    repeat (3) step();
    reset  = 1'b0;
    mon_en = 1'b1;

    // Reset state
    chk("rst_gnt",    32'({gnt0, gnt1, done0, done1}), 32'd0);
    chk("rst_y_lo",   y_lo, 32'd0);
    chk("rst_flags",  32'({n, z, v, c}), 32'd0);
    chk("rst_alu_fs", 32'(alu_fs), 32'h13);
    chk("rst_alu_st", alu_s | alu_t, 32'd0);

    // Single port-0 add: 5 + 7
    sb.push_back('{1'b0, 32'd12, 4'b0000});
    drive(1'b0, 5'h02, 32'd5, 32'd7);
    step();
    tg = cyc;
    chk("gnt0_lat",  32'(gnt0), 32'd1);
    chk("exec_fs",   32'(alu_fs), 32'h02);
    chk("exec_s",    alu_s, 32'd5);
    chk("exec_t",    alu_t, 32'd7);
    wait_done(1'b0, ta);
    chk("done0_lat", 32'(ta - tg), 32'd1);
    step();
    req0 = 1'b0;

    // Simultaneous requests after reset: port 0 first, port 1 three cycles later
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.push_back('{1'b0, 32'd0,   4'b0100});
    sb.push_back('{1'b1, 32'hFF,  4'b0000});
    drive(1'b0, 5'h03, 32'd3, 32'd3);
    drive(1'b1, 5'h09, 32'hF0, 32'h0F);
    wait_done(1'b0, ta);
    step();
    req0 = 1'b0;
    wait_done(1'b1, tb);
    chk("done_gap", 32'(tb - ta), 32'd3);
    step();
    req1 = 1'b0;

    // Both ports held requesting for four operations: order 0,1,0,1
    sb.push_back('{1'b0, 32'd3,        4'b0000});
    sb.push_back('{1'b1, 32'hFFFFFFFD, 4'b1001});
    sb.push_back('{1'b0, 32'd3,        4'b0000});
    sb.push_back('{1'b1, 32'hFFFFFFFD, 4'b1001});
    drive(1'b0, 5'h02, 32'd1, 32'd2);
    drive(1'b1, 5'h03, 32'd2, 32'd5);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done0 | done1) cnt++;
      if (cnt == 4) break;
    end
    chk("rr_ops", 32'(cnt), 32'd4);
    step();
    req0 = 1'b0;
    req1 = 1'b0;

    // Signed overflow on port 1
    sb.push_back('{1'b1, 32'h80000000, 4'b1010});
    drive(1'b1, 5'h02, 32'h7FFFFFFF, 32'd1);
    wait_done(1'b1, ta);
    step();
    req1 = 1'b0;

    // Unassigned FS code passes through untouched
    sb.push_back('{1'b0, 32'hAAAAAAAA, 4'b1000});
    drive(1'b0, 5'h1F, 32'hA5A5A5A5, 32'h0F0F0F0F);
    step();
    chk("fwd_fs", 32'(alu_fs), 32'h1F);
    wait_done(1'b0, ta);
    step();
    req0 = 1'b0;

    // Reset during EXEC of port 0 abandons it; pending port 1 is served afterwards
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.push_back('{1'b1, 32'hFF, 4'b0000});
    drive(1'b0, 5'h02, 32'd5, 32'd7);
    drive(1'b1, 5'h09, 32'hF0, 32'h0F);
    step();
    chk("abort_gnt0", 32'(gnt0), 32'd1);
    reset = 1'b1;
    req0  = 1'b0;
    step();
    reset = 1'b0;
    chk("abort_y_lo",   y_lo, 32'd0);
    chk("abort_alu_fs", 32'(alu_fs), 32'h13);
    chk("abort_done",   32'({done0, done1}), 32'd0);
    wait_done(1'b1, ta);
    step();
    req1 = 1'b0;

    // Idle for ten cycles with no requests
    step();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_alu_fs", 32'(alu_fs), 32'h13);
      chk("idle_alu_st", alu_s | alu_t, 32'd0);
      chk("idle_pulses", 32'({gnt0, gnt1, done0, done1}), 32'd0);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: IDLE_FS, 5'h13, FS code driven to the shared ALU when no operation is in flight (ZEROS).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  operation request from requester 0 / 1; held high until that port's done.
REQ-005 fs0, fs1  input  5 each  function select for the request; stable while req high.
REQ-006 s0, t0, s1, t1  input  32 each  operands for the request; stable while req high.
REQ-007 gnt0, gnt1  output  1 each  one-cycle pulse: request accepted, operands latched.
REQ-008 done0, done1  output  1 each  one-cycle pulse: y_lo and flags valid for that port.
REQ-009 y_lo  output  32  captured ALU result, shared by both ports, valid with done.
REQ-010 n, z, v, c  output  1 each  captured ALU flags, valid with done.
REQ-011 alu_fs  output  5  function select to shared ALU.
REQ-012 alu_s, alu_t  output  32 each  operands to shared ALU.
REQ-013 alu_y_lo  input  32  ALU result (combinational from alu_fs/alu_s/alu_t).
REQ-014 alu_n, alu_z, alu_v, alu_c  input  1 each  ALU flags.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, DONE; one state per cycle.
REQ-016 IDLE: if no req, stay IDLE; if any req, latch winner's fs/s/t into operand registers, set gnt of winner in the next cycle, go EXEC.
REQ-017 Arbitration SHALL be round-robin: single req wins; both req -> port not served last wins; last-served pointer updates on grant only.
REQ-018 EXEC: alu_fs/alu_s/alu_t SHALL be driven from operand registers; gntX high for this cycle only; at end of cycle capture alu_y_lo and alu_n/z/v/c into y_lo/n/z/v/c; go DONE.
REQ-019 DONE: doneX high for served port only, this cycle only; y_lo/flags hold captured values until next capture; go IDLE unconditionally.
REQ-020 req inputs SHALL be ignored in EXEC and DONE; a req still high in the IDLE cycle after DONE is a new request.
REQ-021 Latency: req sampled high in IDLE at edge k -> gnt during cycle k..k+1 -> done during cycle k+1..k+2; throughput one op per 3 cycles.
REQ-022 In IDLE and DONE alu_fs SHALL equal IDLE_FS and alu_s = alu_t = 0.
REQ-023 FS codes SHALL be forwarded unmodified (including 0C-0E and >19); flags captured bit-for-bit including x values.
REQ-024 gnt0&gnt1 and done0&done1 SHALL never be high together; gnt and done never high in same cycle.
REQ-025 The losing port's request SHALL remain pending and be served in the next IDLE arbitration.

Reset
REQ-026 On reset: state IDLE, last-served pointer = 1 (port 0 wins first tie), gnt0/1 = 0, done0/1 = 0, y_lo = 0, n/z/v/c = 0, operand registers = 0, alu_fs = IDLE_FS.
REQ-027 Reset asserted in EXEC or DONE SHALL abandon the operation: no done pulse, outputs take reset values the next cycle.

Verification
REQ-028 req0, fs0=02, s0=5, t0=7 -> gnt0 1 cycle later, done0 2 cycles after sample, y_lo=12, n=0, z=0, v=0, c=0.
REQ-029 req0 and req1 same cycle after reset (fs0=03 s0=3 t0=3; fs1=09 s1=F0 t1=0F) -> port 0 first: y_lo=0, z=1; then port 1: y_lo=FF, done1 three cycles after done0.
REQ-030 both ports held requesting continuously for 4 ops -> grants alternate 0,1,0,1; no double gnt/done.
REQ-031 fs1=02, s1=7FFFFFFF, t1=1 -> y_lo=80000000, n=1, v=1, c=0, on done1 only.
REQ-032 reset asserted during EXEC of a port-0 op -> no done0, y_lo=0, alu_fs=13 next cycle; pending req1 then served normally.
REQ-033 idle with no req for 10 cycles -> alu_fs=13, alu_s=alu_t=0, all gnt/done low throughout.
